// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if: digit/control inputs and anode/segment outputs of the scan driver
// master: timer datapath side (drives digits, dp_en, blank_lz, blink; reads ssd_ctrl, ssd_out)
// slave:  display driver side (reads digits and controls; drives active-low ssd_ctrl, ssd_out)
interface ssd_scan_driver_if;
  logic [3:0] digit_0;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic [3:0] digit_3;
  logic [3:0] dp_en;
  logic       blank_lz;
  logic       blink;
  logic [3:0] ssd_ctrl;
  logic [7:0] ssd_out;
  modport master (output digit_0, digit_1, digit_2, digit_3, dp_en, blank_lz, blink,
                  input ssd_ctrl, ssd_out);
  modport slave (input digit_0, digit_1, digit_2, digit_3, dp_en, blank_lz, blink,
                 output ssd_ctrl, ssd_out);
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: registered 4-digit seven-segment scan driver with zero blanking, dp and blink
// clk, reset: single clock, synchronous active-high reset
// s: digit_0..3 BCD (digit_3 leftmost), dp_en per digit, blank_lz, blink in;
//    ssd_ctrl anodes and ssd_out {a..g,dp} out, both active-low
module ssd_scan_driver #(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int BLINK_DIV_BITS = 25
) (
  input logic clk,
  input logic reset,
  ssd_scan_driver_if.slave s
);
  logic [SCAN_DIV_BITS-1:0]  scan_q, scan_d;
  logic [BLINK_DIV_BITS-1:0] bcnt_q, bcnt_d;
  logic [1:0] idx_q, idx_d;
  logic       phase_q, phase_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic [7:0] out_q, out_d;
  logic       bl1, bl2, bl3, blank, dark;
  logic [3:0] dig;
  logic [6:0] seg;
  always_comb begin
    scan_d  = scan_q + SCAN_DIV_BITS'(1);
    idx_d   = &scan_q ? idx_q + 2'd1 : idx_q;
    bcnt_d  = s.blink ? bcnt_q + BLINK_DIV_BITS'(1) : '0;
    phase_d = s.blink ? phase_q ^ (&bcnt_q) : 1'b1;
    // blanking ripples rightward only while every digit to the left is blanked
    bl3     = s.blank_lz & (s.digit_3 == 4'd0);
    bl2     = bl3 & (s.digit_2 == 4'd0);
    bl1     = bl2 & (s.digit_1 == 4'd0);
    dig     = idx_q == 2'd0 ? s.digit_0 : idx_q == 2'd1 ? s.digit_1 :
              idx_q == 2'd2 ? s.digit_2 : s.digit_3;
    blank   = idx_q == 2'd1 ? bl1 : idx_q == 2'd2 ? bl2 : idx_q == 2'd3 ? bl3 : 1'b0;
    case (dig)
      4'd0:    seg = 7'h01;
      4'd1:    seg = 7'h4F;
      4'd2:    seg = 7'h12;
      4'd3:    seg = 7'h06;
      4'd4:    seg = 7'h4C;
      4'd5:    seg = 7'h24;
      4'd6:    seg = 7'h20;
      4'd7:    seg = 7'h0F;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h04;
      default: seg = 7'h7E;
    endcase
    // gating on the live blink input lets a dropped blink show on the very next edge
    dark    = s.blink & ~phase_q;
    ctrl_d  = dark ? 4'hF : ~(4'b0001 << idx_q);
    out_d   = dark ? 8'hFF : {blank ? 7'h7F : seg, ~s.dp_en[idx_q]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q  <= '0;
      bcnt_q  <= '0;
      idx_q   <= 2'd0;
      phase_q <= 1'b1;
      ctrl_q  <= 4'hF;
      out_q   <= 8'hFF;
    end else begin
      scan_q  <= scan_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      ctrl_q  <= ctrl_d;
      out_q   <= out_d;
    end
  end
  assign s.ssd_ctrl = ctrl_q;
  assign s.ssd_out  = out_q;
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Downstream display stage for the countdown timer datapath: consumes the four BCD digit nibbles produced by the digit counters.
- Time-multiplexes the digits onto the board's 4-anode seven-segment display and decodes each digit to segments.
- Adds leading-zero blanking, per-digit decimal points and whole-display blinking (used for the "time up" indication).
- Replaces the ad-hoc select/decoder pair with one registered, glitch-free driver.

Parameters:
- SCAN_DIV_BITS, 17: width of the free-running scan divider; the digit index advances once every 2^SCAN_DIV_BITS clocks.
- BLINK_DIV_BITS, 25: width of the blink divider; the blink phase toggles once every 2^BLINK_DIV_BITS clocks.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- digit_0  input  4  ones digit (BCD); rightmost position.
- digit_1  input  4  tens digit.
- digit_2  input  4  hundreds digit.
- digit_3  input  4  thousands digit; leftmost position.
- dp_en  input  4  bit i lights the decimal point of digit i.
- blank_lz  input  1  1 = blank leading zeros.
- blink  input  1  1 = flash the whole display.
- ssd_ctrl  output  4  anode enables, active-low; bit i = digit i.
- ssd_out  output  8  segments {a,b,c,d,e,f,g,dp}, active-low.

Behaviour:
- Reset state:
  - scan counter = 0, digit index = 0.
  - blink counter = 0, blink phase = 1 (visible).
  - ssd_ctrl = 4'b1111, ssd_out = 8'hFF.
- Scan counter:
  - Increments every clk and wraps.
  - scan tick = counter at all-ones. On a tick, the index advances 0→1→2→3→0.
- Outputs:
  - Registered, with 1-clk latency from the index and all inputs. Inputs are sampled every clk, so a changed digit value appears on the next edge without waiting for a scan tick.
  - Exactly one anode is low at any time (index i → bit i low), except during reset or the blink dark phase.
- Decode (active-low):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09.
  - Values A–F decode to a dash, 8'hFD (g only).
  - Decimal point: ssd_out[0] = ~dp_en[index], applied after decode and also on blanked or dash digits.
- Leading-zero blanking (blank_lz=1):
  - digit_3 is blanked if 0.
  - digit_2 is blanked if 0 and digit_3 is blanked.
  - digit_1 is blanked if 0 and digit_2 is blanked.
  - digit_0 is never blanked.
  - A blanked digit keeps its anode asserted; its segments a–g are all 1.
- Blink:
  - While blink=0: blink counter held at 0, phase held at 1.
  - While blink=1: the counter runs and the phase toggles on wrap, so the first half-period is visible.
  - Phase 0 → ssd_ctrl = 1111 and ssd_out = FF. The scan counter keeps running.
  - Deasserting blink restores the visible display on the next edge.
- Simultaneous events: a scan tick and a blink toggle in the same cycle are independent. The next output reflects both the new index and the new phase.
- Reset mid-operation: on the next edge all state returns to the reset values, regardless of the scan position or blink phase.

Test Plan:
- Scan order (SCAN_DIV_BITS=2, BLINK_DIV_BITS=4): assert reset 3 clks → ssd_ctrl=1111, ssd_out=FF. Release → ssd_ctrl sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 clks.
- Blanking, countdown start: digit_3..0 = 0,0,4,0, blank_lz=1 → index0 ssd_out=03; index1 ssd_out=99; index2 and index3 anodes low with ssd_out=FF. With blank_lz=0, index2 and index3 show 03.
- Timer at zero: digits = 0,0,0,0, blank_lz=1 → only index0 shows 03; the other three positions show FF.
- Blink: blink=1 with digits 0,0,3,9 → 16 clks of normal scanning (index0=09, index1=0D), then 16 clks of ssd_ctrl=1111 / ssd_out=FF, repeating. Drop blink during the dark phase → visible on the next edge.
- Decode and dp: digit_0 = 4'hB with dp_en = 0001 → index0 ssd_out=FC. digit_0 = 8 → 00. Change digit_0 mid-slot → ssd_out updates 1 clk later.
- Mid-operation reset: pulse reset for 1 clk during blink dark phase at index 2 → next edge gives 1111/FF. The following edge shows index0 visible, and the scan restarts with a full 4-clk slot.
